// File: rtl/ppu_types_pkg.sv
// Shared PPU types: OBJ FIFO pixel format, fetcher state encoding and the
// sprite row/VRAM address helper used by the object fetcher.
package ppu_types_pkg;

   localparam int FIFO_DEPTH = 8;

   typedef struct packed {
      logic [1:0] colour;
      logic [2:0] palette;
      logic       bg_priority;
      logic [3:0] spr_idx;
      logic       valid;
   } pixel_t;

   typedef enum logic [2:0] {
      IDLE,
      LO_ADDR,
      LO_DATA,
      HI_ADDR,
      HI_DATA,
      PUSH
   } fetch_state_t;

   // (ly + 16 - spr_y) mod 16 is simply the low nibble of ly - spr_y.
   function automatic logic [12:0] obj_vram_addr(input logic [7:0] scan_line,
                                                 input logic [7:0] y_pos,
                                                 input logic [7:0] tile,
                                                 input logic       yflip,
                                                 input logic       tall,
                                                 input logic       plane);
      logic [7:0] diff;
      logic [3:0] row;
      logic [7:0] tile_idx;
      diff = scan_line - y_pos;
      row = diff[3:0];
      if (yflip)
         row = (tall ? 4'd15 : 4'd7) - row;
      tile_idx = tall ? {tile[7:1], row[3]} : tile;
      return {1'b0, tile_idx, row[2:0], plane};
   endfunction

endpackage

// File: rtl/obj_pixel_decode.sv
// Combinational decode of two tile bitplanes into eight OBJ FIFO pixels,
// applying horizontal flip and left-edge clipping for sprites with x < 8.
module obj_pixel_decode
   import ppu_types_pkg::*;
(
   input  logic [7:0]                lo_plane,
   input  logic [7:0]                hi_plane,
   input  logic [7:0]                spr_x,
   input  logic                      xflip,
   input  logic [2:0]                palette,
   input  logic                      bg_priority,
   input  logic [3:0]                spr_idx,
   output pixel_t [FIFO_DEPTH-1:0]   pixels
);

   pixel_t [FIFO_DEPTH-1:0] raw;
   logic [7:0] clip_diff;
   logic [3:0] shift;

   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         logic [2:0] bit_sel;
         bit_sel = xflip ? 3'(i) : 3'(7 - i);
         raw[i] = '0;
         raw[i].colour      = {hi_plane[bit_sel], lo_plane[bit_sel]};
         raw[i].palette     = palette;
         raw[i].bg_priority = bg_priority;
         raw[i].spr_idx     = spr_idx;
         raw[i].valid       = ({hi_plane[bit_sel], lo_plane[bit_sel]} != 2'b00);
      end
   end

   // Sprites partly off the left edge slide left; vacated slots become empty pixels.
   always_comb begin
      clip_diff = 8'd8 - spr_x;
      shift = (spr_x < 8'd8) ? clip_diff[3:0] : 4'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         logic [3:0] src;
         src = 4'(i) + shift;
         pixels[i] = '0;
         if (!src[3])
            pixels[i] = raw[src[2:0]];
      end
   end

endmodule

// File: rtl/obj_fetcher.sv
// Sprite tile fetcher: reads both bitplanes of one sprite row and pushes eight
// decoded pixels to the OBJ FIFO. Define OBJ_FETCH_CGB_EN for CGB bank/palette.
module obj_fetcher
   import ppu_types_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [7:0]               spr_y,
   input  logic [7:0]               spr_x,
   input  logic [7:0]               spr_tile,
   input  logic [7:0]               spr_flags,
   input  logic [3:0]               spr_idx,
   input  logic [7:0]               ly,
   input  logic                     obj_size,
   input  logic                     abort,
   output logic                     vram_rd,
   output logic [12:0]              vram_addr,
   output logic                     vram_bank,
   input  logic [7:0]               vram_rdata,
   output logic                     fifo_we,
   output pixel_t [FIFO_DEPTH-1:0]  fifo_wdata,
   output logic                     busy,
   output logic                     done
);

   fetch_state_t state;

   logic [7:0] lat_y;
   logic [7:0] lat_x;
   logic [7:0] lat_tile;
   logic [7:0] lat_flags;
   logic [3:0] lat_idx;
   logic [7:0] lat_ly;
   logic       lat_size;
   logic [7:0] lo_plane;
   logic [7:0] hi_plane;

   logic [2:0] pix_palette;
   logic       start_bank;
   logic       lat_bank;
   pixel_t [FIFO_DEPTH-1:0] decoded;

`ifdef OBJ_FETCH_CGB_EN
   logic unused_flags;
   assign pix_palette  = lat_flags[2:0];
   assign start_bank   = spr_flags[3];
   assign lat_bank     = lat_flags[3];
   assign unused_flags = lat_flags[4];
`else
   logic unused_flags;
   assign pix_palette  = {2'b00, lat_flags[4]};
   assign start_bank   = 1'b0;
   assign lat_bank     = 1'b0;
   assign unused_flags = ^lat_flags[3:0];
`endif

   obj_pixel_decode u_decode (
      .lo_plane    (lo_plane),
      .hi_plane    (hi_plane),
      .spr_x       (lat_x),
      .xflip       (lat_flags[5]),
      .palette     (pix_palette),
      .bg_priority (lat_flags[7]),
      .spr_idx     (lat_idx),
      .pixels      (decoded)
   );

   // Both planes are held until PUSH, so the pixel bus only needs gating.
   assign fifo_wdata = fifo_we ? decoded : '0;

   // The low-plane address comes straight from the inputs on the start edge;
   // the high-plane address is rebuilt from the latched attributes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         vram_rd   <= 1'b0;
         vram_addr <= '0;
         vram_bank <= 1'b0;
         fifo_we   <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         lat_y     <= '0;
         lat_x     <= '0;
         lat_tile  <= '0;
         lat_flags <= '0;
         lat_idx   <= '0;
         lat_ly    <= '0;
         lat_size  <= 1'b0;
         lo_plane  <= '0;
         hi_plane  <= '0;
      end else if (abort) begin
         state     <= IDLE;
         vram_rd   <= 1'b0;
         vram_addr <= '0;
         vram_bank <= 1'b0;
         fifo_we   <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         vram_rd   <= 1'b0;
         vram_addr <= '0;
         vram_bank <= 1'b0;
         fifo_we   <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lat_y     <= spr_y;
                  lat_x     <= spr_x;
                  lat_tile  <= spr_tile;
                  lat_flags <= spr_flags;
                  lat_idx   <= spr_idx;
                  lat_ly    <= ly;
                  lat_size  <= obj_size;
                  state     <= LO_ADDR;
                  busy      <= 1'b1;
                  vram_rd   <= 1'b1;
                  vram_bank <= start_bank;
                  vram_addr <= obj_vram_addr(ly, spr_y, spr_tile, spr_flags[6],
                                             obj_size, 1'b0);
               end
            end
            LO_ADDR: state <= LO_DATA;
            LO_DATA: begin
               lo_plane  <= vram_rdata;
               state     <= HI_ADDR;
               vram_rd   <= 1'b1;
               vram_bank <= lat_bank;
               vram_addr <= obj_vram_addr(lat_ly, lat_y, lat_tile, lat_flags[6],
                                          lat_size, 1'b1);
            end
            HI_ADDR: state <= HI_DATA;
            HI_DATA: begin
               hi_plane <= vram_rdata;
               state    <= PUSH;
               fifo_we  <= 1'b1;
               done     <= 1'b1;
            end
            PUSH: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_obj_fetcher.sv
// Scoreboard bench for obj_fetcher: stimulus queues expected VRAM reads and
// FIFO pushes, a negedge monitor pops and compares them as the DUT emits them.
module tb_obj_fetcher;
   import ppu_types_pkg::*;

   typedef pixel_t [FIFO_DEPTH-1:0] pix_row_t;
   typedef struct {
      pix_row_t px;
      int       cyc;
   } exp_push_t;

   logic       clk;
   logic       reset;
   logic       start;
   logic [7:0] spr_y, spr_x, spr_tile, spr_flags;
   logic [3:0] spr_idx;
   logic [7:0] ly;
   logic       obj_size;
   logic       abort;
   logic       vram_rd;
   logic [12:0] vram_addr;
   logic       vram_bank;
   logic [7:0] vram_rdata;
   logic       fifo_we;
   pix_row_t   fifo_wdata;
   logic       busy;
   logic       done;

   int pass_cnt = 0;
   int check_cnt = 0;
   int cyc = 0;
   bit mon_en = 0;
   logic [7:0] cur_lo = 8'h00;
   logic [7:0] cur_hi = 8'h00;
   logic rd_pending = 1'b0;
   logic rd_plane = 1'b0;

   logic [13:0] addr_q[$];
   exp_push_t   push_q[$];

   obj_fetcher dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .spr_y      (spr_y),
      .spr_x      (spr_x),
      .spr_tile   (spr_tile),
      .spr_flags  (spr_flags),
      .spr_idx    (spr_idx),
      .ly         (ly),
      .obj_size   (obj_size),
      .abort      (abort),
      .vram_rd    (vram_rd),
      .vram_addr  (vram_addr),
      .vram_bank  (vram_bank),
      .vram_rdata (vram_rdata),
      .fifo_we    (fifo_we),
      .fifo_wdata (fifo_wdata),
      .busy       (busy),
      .done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic reportFail(input string name, input logic [127:0] act);
      check_cnt++;
      $display("[TB] FAIL %s: got %0h, expected nothing", name, act);
   endtask

   function automatic logic [2:0] exp_pal(input logic [7:0] f);
`ifdef OBJ_FETCH_CGB_EN
      return f[2:0];
`else
      return {2'b00, f[4]};
`endif
   endfunction

   function automatic logic exp_bank(input logic [7:0] f);
`ifdef OBJ_FETCH_CGB_EN
      return f[3];
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [15:0] pk(input int c0, input int c1, input int c2, input int c3,
                                      input int c4, input int c5, input int c6, input int c7);
      return {c7[1:0], c6[1:0], c5[1:0], c4[1:0], c3[1:0], c2[1:0], c1[1:0], c0[1:0]};
   endfunction

   function automatic pix_row_t build(input logic [15:0] cols, input logic [7:0] vis,
                                      input logic [7:0] flags, input logic [3:0] idx);
      pix_row_t r;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         r[i] = '0;
         if (vis[i]) begin
            r[i].colour      = cols[2*i +: 2];
            r[i].palette     = exp_pal(flags);
            r[i].bg_priority = flags[7];
            r[i].spr_idx     = idx;
            r[i].valid       = (cols[2*i +: 2] != 2'b00);
         end
      end
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issues a one-cycle start; returns one cycle later (fetcher in LO_ADDR).
   task automatic applyStimulus(input logic [7:0] y, input logic [7:0] x, input logic [7:0] tile,
                                input logic [7:0] flags, input logic [3:0] idx, input logic [7:0] line,
                                input logic sz, input logic [7:0] lo, input logic [7:0] hi,
                                input logic [12:0] a_lo, input logic [15:0] cols,
                                input logic [7:0] vis, input int nreads, input bit expect_push);
      exp_push_t e;
      spr_y = y; spr_x = x; spr_tile = tile; spr_flags = flags; spr_idx = idx;
      ly = line; obj_size = sz; cur_lo = lo; cur_hi = hi;
      addr_q.push_back({exp_bank(flags), a_lo});
      if (nreads > 1) addr_q.push_back({exp_bank(flags), a_lo | 13'h0001});
      if (expect_push) begin
         e.px = build(cols, vis, flags, idx);
         e.cyc = cyc + 5;
         push_q.push_back(e);
      end
      start = 1'b1;
      idle(1);
      start = 1'b0;
   endtask

   // VRAM model: data for the plane requested appears the cycle after vram_rd.
   always @(negedge clk) begin
      rd_pending = vram_rd;
      rd_plane = vram_addr[0];
   end

   always @(posedge clk) begin
      #1;
      vram_rdata = rd_pending ? (rd_plane ? cur_hi : cur_lo) : 8'hA5;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (vram_rd) begin
            if (addr_q.size() == 0) reportFail("unexpected_read", {vram_bank, vram_addr});
            else checkOutput("vram_addr", {vram_bank, vram_addr}, addr_q.pop_front());
         end
         if (fifo_we) begin
            checkOutput("done_with_push", done, 1'b1);
            if (push_q.size() == 0) reportFail("unexpected_push", fifo_wdata);
            else begin
               exp_push_t e;
               e = push_q.pop_front();
               checkOutput("push_cycle", cyc, e.cyc);
               checkOutput("fifo_wdata", fifo_wdata, e.px);
            end
         end else begin
            checkOutput("done_idle", done, 1'b0);
            checkOutput("wdata_idle_zero", fifo_wdata, 128'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      spr_y = 0; spr_x = 0; spr_tile = 0; spr_flags = 0; spr_idx = 0;
      ly = 0; obj_size = 1'b0; vram_rdata = 8'h00;
      #1;
      checkOutput("reset_state", {busy, done, fifo_we, vram_rd, vram_bank, vram_addr}, 128'h0);
      checkOutput("reset_wdata", fifo_wdata, 128'h0);
      idle(2);
      reset = 1'b0;
      mon_en = 1;
      idle(2);

      $display("[TB] 8x8 plain fetch");
      applyStimulus(8'd16, 8'd8, 8'h12, 8'h00, 4'd3, 8'd20, 1'b0, 8'hF0, 8'hCC, 13'h0128,
                    pk(3,3,1,1,2,2,0,0), 8'hFF, 2, 1'b1);
      checkOutput("busy_in_fetch", busy, 1'b1);
      idle(3);
      checkOutput("busy_before_push", busy, 1'b1);
      idle(2);
      checkOutput("busy_after_push", busy, 1'b0);
      idle(3);

      $display("[TB] 8x8 x+y flip");
      applyStimulus(8'd16, 8'd8, 8'h12, 8'h60, 4'd3, 8'd20, 1'b0, 8'hF0, 8'hCC, 13'h0126,
                    pk(0,0,2,2,1,1,3,3), 8'hFF, 2, 1'b1);
      idle(8);

      $display("[TB] 8x16 lower tile, priority + DMG palette 1");
      applyStimulus(8'd16, 8'd20, 8'h13, 8'h90, 4'd7, 8'd28, 1'b1, 8'h0F, 8'h33, 13'h0138,
                    pk(0,0,2,2,1,1,3,3), 8'hFF, 2, 1'b1);
      idle(8);

      $display("[TB] 8x16 yflip selects upper tile");
      applyStimulus(8'd16, 8'd100, 8'h13, 8'h40, 4'd1, 8'd28, 1'b1, 8'h81, 8'h00, 13'h0126,
                    pk(1,0,0,0,0,0,0,1), 8'hFF, 2, 1'b1);
      idle(8);

      $display("[TB] left-edge clip x=5");
      applyStimulus(8'd16, 8'd5, 8'h20, 8'h80, 4'd9, 8'd16, 1'b0, 8'hFF, 8'h00, 13'h0200,
                    pk(1,1,1,1,1,0,0,0), 8'h1F, 2, 1'b1);
      idle(8);

      $display("[TB] left-edge clip x=7");
      applyStimulus(8'd16, 8'd7, 8'h20, 8'h00, 4'd2, 8'd16, 1'b0, 8'h80, 8'h01, 13'h0200,
                    pk(0,0,0,0,0,0,2,0), 8'h7F, 2, 1'b1);
      idle(8);

      $display("[TB] x=0 fully hidden but still pushed");
      applyStimulus(8'd16, 8'd0, 8'h20, 8'h00, 4'd4, 8'd16, 1'b0, 8'hFF, 8'hFF, 13'h0200,
                    pk(0,0,0,0,0,0,0,0), 8'h00, 2, 1'b1);
      idle(8);

      $display("[TB] row wrap and CGB flags 0x0D");
      applyStimulus(8'd250, 8'd8, 8'h01, 8'h0D, 4'd15, 8'd3, 1'b0, 8'hAA, 8'h55, 13'h0012,
                    pk(1,2,1,2,1,2,1,2), 8'hFF, 2, 1'b1);
      idle(8);

      $display("[TB] second start while busy is ignored");
      applyStimulus(8'd16, 8'd8, 8'h44, 8'h00, 4'd5, 8'd18, 1'b0, 8'h3C, 8'hC3, 13'h0444,
                    pk(2,2,1,1,1,1,2,2), 8'hFF, 2, 1'b1);
      idle(1);
      spr_tile = 8'hEE; spr_flags = 8'h60; ly = 8'd99; spr_y = 8'd0; spr_x = 8'd0;
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(8);

      $display("[TB] abort in HI_ADDR");
      applyStimulus(8'd16, 8'd8, 8'h30, 8'h00, 4'd0, 8'd16, 1'b0, 8'hFF, 8'hFF, 13'h0300,
                    pk(0,0,0,0,0,0,0,0), 8'h00, 2, 1'b0);
      idle(2);
      abort = 1'b1;
      idle(1);
      abort = 1'b0;
      checkOutput("busy_after_abort", busy, 1'b0);
      idle(6);

      $display("[TB] abort beats start");
      spr_tile = 8'h31; spr_y = 8'd16; ly = 8'd16; spr_flags = 8'h00; spr_x = 8'd8;
      start = 1'b1; abort = 1'b1;
      idle(1);
      start = 1'b0; abort = 1'b0;
      checkOutput("abort_beats_start", busy, 1'b0);
      idle(6);

      $display("[TB] reset in LO_DATA");
      applyStimulus(8'd16, 8'd8, 8'h50, 8'h00, 4'd6, 8'd16, 1'b0, 8'hFF, 8'hFF, 13'h0500,
                    pk(0,0,0,0,0,0,0,0), 8'h00, 1, 1'b0);
      idle(1);
      reset = 1'b1;
      #1;
      checkOutput("reset_mid_fetch", {busy, done, fifo_we, vram_rd, vram_bank, vram_addr}, 128'h0);
      checkOutput("reset_mid_wdata", fifo_wdata, 128'h0);
      idle(1);
      reset = 1'b0;
      idle(10);
      checkOutput("busy_after_reset", busy, 1'b0);

      for (int k = 0; k < 50 && (addr_q.size() != 0 || push_q.size() != 0); k++)
         @(posedge clk);
      #1;
      checkOutput("pending_reads", addr_q.size(), 0);
      checkOutput("pending_pushes", push_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
